branch_resolve_queue: RTL and testbench

Tracks every conditional branch from decode, where `branch_history_predictor` issues its prediction, to mem, where the branch resolves. On resolution the block compares the actual outcome with the stored prediction. It drives the predictor's update port (`branch_mem_sig`, `update_branch_addr`, `actual_branch_decision`) and raises a one-cycle mispredict/redirect to the fetch stage. Between the two stages it is a small in-order FIFO of in-flight predictions.

---
 rtl/branch_pkg.sv | 13 +
 rtl/branch_queue_fifo.sv | 78 +++++++
 rtl/branch_resolve_queue.sv | 118 +++++++++++
 tb/tb_branch_resolve_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_pkg;

    localparam int unsigned BRANCH_ADDR_W = 32;
    localparam int unsigned PC_INC        = 4;

    typedef struct packed {
        logic [BRANCH_ADDR_W-1:0] pc;
        logic                     pred;
        logic [BRANCH_ADDR_W-1:0] target;
    } branch_entry_t;

endpackage

// File: rtl/branch_queue_fifo.sv
// Circular buffer of in-flight branch entries with push/pop/clear and registered status.
module branch_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH)-1:0] tail
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop && !empty_q;
    // A full queue can still accept a push when the head slot frees in the same cycle.
    assign push_ok = push && (!full_q || pop_ok) && !clear;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + PW'(1);
            if (pop_ok)  head_d = head_q + PW'(1);
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_q] <= wdata;
    end

    assign rdata = mem[head_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign head  = head_q;
    assign tail  = tail_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of predicted branches from decode to mem; drives predictor update and redirect.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = BRANCH_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    input  logic [ADDR_W-1:0]      dec_pc,
    input  logic                   dec_pred,
    input  logic [ADDR_W-1:0]      dec_target,
    input  logic                   mem_valid,
    input  logic                   mem_taken,
    input  logic [ADDR_W-1:0]      mem_target,
    output logic                   upd_valid,
    output logic [ADDR_W-1:0]      upd_addr,
    output logic                   upd_taken,
    output logic                   mispredict,
    output logic [ADDR_W-1:0]      redirect_pc,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]            stat_resolved,
    output logic [31:0]            stat_mispred
`endif
);
    localparam int unsigned EW = 2 * ADDR_W + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    logic [EW-1:0]     wdata, rdata;
    logic [ADDR_W-1:0] h_pc, h_target, redirect;
    logic              h_pred, pop_ok, wrong, flush, err_set;
    logic [PW-1:0]     head, tail;

    assign wdata    = {dec_pc, dec_pred, dec_target};
    assign h_pc     = rdata[EW-1 -: ADDR_W];
    assign h_pred   = rdata[ADDR_W];
    assign h_target = rdata[ADDR_W-1:0];

    assign pop_ok   = mem_valid && !empty;
    assign wrong    = (h_pred != mem_taken) || (mem_taken && (h_target != mem_target));
    assign flush    = pop_ok && wrong;
    assign redirect = mem_taken ? mem_target : h_pc + ADDR_W'(PC_INC);
    // Pushing into a full queue is only an error when the head is not leaving this cycle.
    assign err_set  = (dec_valid && full && !mem_valid) || (mem_valid && empty);

    branch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dec_valid && !flush),
        .wdata (wdata),
        .pop   (pop_ok),
        .clear (flush),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head),
        .tail  (tail)
    );

    logic              upd_valid_q, upd_taken_q, mispredict_q, err_q;
    logic [ADDR_W-1:0] upd_addr_q, redirect_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            upd_valid_q  <= pop_ok;
            mispredict_q <= flush;
            if (pop_ok) begin
                upd_addr_q  <= h_pc;
                upd_taken_q <= mem_taken;
            end
            if (flush) redirect_pc_q <= redirect;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_addr    = upd_addr_q;
    assign upd_taken   = upd_taken_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign err         = err_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (pop_ok && (stat_resolved_q != 32'hFFFF_FFFF)) stat_resolved_q <= stat_resolved_q + 32'd1;
            if (flush && (stat_mispred_q != 32'hFFFF_FFFF))   stat_mispred_q  <= stat_mispred_q + 32'd1;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed-vector bench: stimulus pushes expected updates into a scoreboard checked by a monitor.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] dec_pc = '0;
    logic        dec_pred = 1'b0;
    logic [31:0] dec_target = '0;
    logic        mem_valid = 1'b0;
    logic        mem_taken = 1'b0;
    logic [31:0] mem_target = '0;
    logic        upd_valid, upd_taken, mispredict, full, empty, err;
    logic [31:0] upd_addr, redirect_pc;
    logic [2:0]  count;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
    logic [31:0] res0, mis0;
`endif

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_pred    (dec_pred),
        .dec_target  (dec_target),
        .mem_valid   (mem_valid),
        .mem_taken   (mem_taken),
        .mem_target  (mem_target),
        .upd_valid   (upd_valid),
        .upd_addr    (upd_addr),
        .upd_taken   (upd_taken),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .err         (err)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic        misp;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every update pulse must match the oldest expected resolution.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got addr 0x%0h, expected no pulse", upd_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("upd_addr", upd_addr, e.addr);
                    check("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                    check("mispredict", {31'd0, mispredict}, {31'd0, e.misp});
                    if (e.misp) check("redirect_pc", redirect_pc, e.redir);
                end
            end else if (mispredict) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_mispredict: got 1, expected 0 without upd_valid");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        dec_valid = 1'b1; dec_pc = pc; dec_pred = pred; dec_target = tgt;
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic do_pop(input logic taken, input logic [31:0] tgt, input logic [31:0] e_addr,
                          input logic e_misp, input logic [31:0] e_redir);
        exp_t e;
        e.addr = e_addr; e.taken = taken; e.misp = e_misp; e.redir = e_redir;
        exp_q.push_back(e);
        mem_valid = 1'b1; mem_taken = taken; mem_target = tgt;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input int c, input logic f, input logic em,
                                input logic er);
        check({tag, "_count"}, {29'd0, count}, c);
        check({tag, "_full"}, {31'd0, full}, {31'd0, f});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, em});
        check({tag, "_err"}, {31'd0, err}, {31'd0, er});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dec_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check_status("reset", 0, 1'b0, 1'b1, 1'b0);
        check("reset_upd_valid", {31'd0, upd_valid}, 32'd0);
        check("reset_upd_addr", upd_addr, 32'd0);
        check("reset_upd_taken", {31'd0, upd_taken}, 32'd0);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);

        // Correct taken prediction.
        do_push(32'h100, 1'b1, 32'h140);
        check_status("push1", 1, 1'b0, 1'b0, 1'b0);
        do_pop(1'b1, 32'h140, 32'h100, 1'b0, 32'h0);
        tick();

        // Predicted not-taken, actually taken.
        do_push(32'h200, 1'b0, 32'h180);
        do_pop(1'b1, 32'h180, 32'h200, 1'b1, 32'h180);
        check_status("flush1", 0, 1'b0, 1'b1, 1'b0);

        // Predicted taken, actually not taken: redirect to pc+4, younger entry flushed.
        do_push(32'h300, 1'b1, 32'h340);
        do_push(32'h304, 1'b1, 32'h380);
        check_status("two", 2, 1'b0, 1'b0, 1'b0);
        do_pop(1'b0, 32'h0, 32'h300, 1'b1, 32'h304);
        check_status("flush2", 0, 1'b0, 1'b1, 1'b0);

        // Correct not-taken prediction.
        do_push(32'h400, 1'b0, 32'h0);
        do_pop(1'b0, 32'h0, 32'h400, 1'b0, 32'h0);
        check_status("nt_ok", 0, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, then push+pop while full, then drain back-to-back.
        for (int i = 0; i < 4; i++) do_push(32'h500 + 32'(4 * i), 1'b1, 32'h600 + 32'(4 * i));
        check_status("fill", 4, 1'b1, 1'b0, 1'b0);
        do_push(32'hDEAD, 1'b1, 32'hBEEF);
        check_status("overflow", 4, 1'b1, 1'b0, 1'b1);
        dec_valid = 1'b1; dec_pc = 32'h510; dec_pred = 1'b1; dec_target = 32'h700;
        do_pop(1'b1, 32'h600, 32'h500, 1'b0, 32'h0);
        dec_valid = 1'b0;
        check_status("full_pp", 4, 1'b1, 1'b0, 1'b1);
        do_pop(1'b1, 32'h604, 32'h504, 1'b0, 32'h0);
        do_pop(1'b1, 32'h608, 32'h508, 1'b0, 32'h0);
        do_pop(1'b1, 32'h60C, 32'h50C, 1'b0, 32'h0);
        do_pop(1'b1, 32'h700, 32'h510, 1'b0, 32'h0);
        check_status("drain", 0, 1'b0, 1'b1, 1'b1);

        // Target mismatch on a correctly predicted direction.
        do_push(32'h100, 1'b1, 32'h140);
`ifdef BRANCH_RESOLVE_STATS_EN
        res0 = stat_resolved;
        mis0 = stat_mispred;
`endif
        do_pop(1'b1, 32'h999, 32'h100, 1'b1, 32'h999);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_mispred_delta", stat_mispred - mis0, 32'd1);
        check("stat_resolved_delta", stat_resolved - res0, 32'd1);
`endif

        // A push coinciding with a flushing pop is discarded.
        do_push(32'h900, 1'b0, 32'h0);
        dec_valid = 1'b1; dec_pc = 32'h904; dec_pred = 1'b0; dec_target = 32'h0;
        do_pop(1'b1, 32'h950, 32'h900, 1'b1, 32'h950);
        dec_valid = 1'b0;
        check_status("flush_push", 0, 1'b0, 1'b1, 1'b1);
        tick();

        // Same-cycle push+pop on empty: push lands, pop counts as pop-when-empty.
        do_reset();
        check_status("reset2", 0, 1'b0, 1'b1, 1'b0);
        dec_valid = 1'b1; dec_pc = 32'h800; dec_pred = 1'b0; dec_target = 32'h0;
        mem_valid = 1'b1; mem_taken = 1'b0; mem_target = 32'h0;
        tick();
        dec_valid = 1'b0; mem_valid = 1'b0;
        check_status("empty_pp", 1, 1'b0, 1'b0, 1'b1);
        do_pop(1'b0, 32'h0, 32'h800, 1'b0, 32'h0);
        tick();

        // Reset mid-operation drops in-flight entries without an update.
        do_push(32'hA00, 1'b1, 32'hA40);
        do_push(32'hA04, 1'b1, 32'hA80);
        do_reset();
        check_status("midreset", 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
